dff_ureg: RTL and testbench

//   Parametrised W-bit universal register built on the dff cell generation.

---
 rtl/dff_ureg.sv | 72 +++++++
 tb/tb_dff_ureg.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dff_ureg.sv
// W-bit universal register: hold, shift right, shift left, parallel load.
// Each bit is a separate flip-flop cell with a complementary output.

// Single storage bit with synchronous active-high reset and complement output.
module dff_ureg_cell #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic C,
    input  logic R,
    input  logic D,
    output logic Q,
    output logic nQ
);

    logic q;

    // Capture next value or reset value on the rising edge.
    always_ff @(posedge C) begin
        if (R) begin
            q <= RESET_VAL;
        end else begin
            q <= D;
        end
    end

    assign Q  = q;
    assign nQ = ~q;

endmodule

// Universal register built from one dff_ureg_cell per bit.
module dff_ureg #(
    parameter int unsigned      W         = 4,
    parameter logic [W-1:0]     RESET_VAL = '0
) (
    input  logic         C,
    input  logic         R,
    input  logic [1:0]   M,
    input  logic [W-1:0] D,
    input  logic         SR,
    input  logic         SL,
    output logic [W-1:0] Q,
    output logic [W-1:0] nQ
);

    logic [W-1:0] d_next;

    // Next-state selection from mode; an unknown mode propagates X into Q.
    always_comb begin
        d_next = Q;
        case (M)
            2'b00:   d_next = Q;
            2'b01:   d_next = {SR, Q[W-1:1]};
            2'b10:   d_next = {Q[W-2:0], SL};
            2'b11:   d_next = D;
            default: d_next = 'x;
        endcase
    end

    for (genvar i = 0; i < W; i++) begin : g_bit
        dff_ureg_cell #(
            .RESET_VAL(RESET_VAL[i])
        ) u_cell (
            .C (C),
            .R (R),
            .D (d_next[i]),
            .Q (Q[i]),
            .nQ(nQ[i])
        );
    end

endmodule

// File: tb/tb_dff_ureg.sv
// Scoreboard bench for dff_ureg: two instances (RESET_VAL 0000 and 0101)
// share the same stimulus and are checked against an arithmetic model.
module tb_dff_ureg;

    logic       C = 1'b0;
    logic       R = 1'b0;
    logic [1:0] M = 2'b00;
    logic [3:0] D = 4'b0000;
    logic       SR = 1'b0;
    logic       SL = 1'b0;
    logic [3:0] q0, nq0, q1, nq1;

    int errors = 0;
    int checks = 0;

    logic [3:0] model0;
    logic [3:0] model1;
    logic [7:0] exp_q[$];
    bit         seen_reset = 1'b0;

    dff_ureg #(.W(4), .RESET_VAL(4'b0000)) dut0 (
        .C(C), .R(R), .M(M), .D(D), .SR(SR), .SL(SL), .Q(q0), .nQ(nq0)
    );

    dff_ureg #(.W(4), .RESET_VAL(4'b0101)) dut1 (
        .C(C), .R(R), .M(M), .D(D), .SR(SR), .SL(SL), .Q(q1), .nQ(nq1)
    );

    always #5 C = ~C;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Register behaviour expressed as integer arithmetic on a 4-bit value.
    function automatic logic [3:0] next_of(input logic [3:0] q, input logic r,
                                           input logic [3:0] rv, input logic [1:0] m,
                                           input logic [3:0] d, input logic sr,
                                           input logic sl);
        int v;
        v = int'(q);
        if (r) return rv;
        case (m)
            2'd0:    return q;
            2'd1:    v = v / 2 + int'(sr) * 8;
            2'd2:    v = (v * 2 + int'(sl)) % 16;
            default: v = int'(d);
        endcase
        return v[3:0];
    endfunction

    task automatic step(input logic r, input logic [1:0] m, input logic [3:0] d,
                        input logic sr, input logic sl);
        @(negedge C);
        R = r; M = m; D = d; SR = sr; SL = sl;
        model0 = next_of(model0, r, 4'b0000, m, d, sr, sl);
        model1 = next_of(model1, r, 4'b0101, m, d, sr, sl);
        if (r) seen_reset = 1'b1;
        exp_q.push_back({model0, model1});
        @(posedge C);
        #2;
    endtask

    // Monitor: every edge the register presents a new state; compare against queue.
    always @(posedge C) begin
        logic [7:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("q0", q0, e[7:4]);
            chk("q1", q1, e[3:0]);
        end
        if (seen_reset) begin
            chk("nq0_inv", nq0, ~q0);
            chk("nq1_inv", nq1, ~q1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        model0 = 'x;
        model1 = 'x;

        // 1: reset from 1010, then hold
        step(1, 2'b00, 4'b0000, 0, 0);
        step(0, 2'b11, 4'b1010, 0, 0);
        chk("t1_pre", q0, 4'b1010);
        step(1, 2'b11, 4'b1111, 1, 1);
        chk("t1_rst_q", q0, 4'b0000);
        chk("t1_rst_nq", nq0, 4'b1111);
        chk("t1_rst_q1", q1, 4'b0101);
        repeat (3) step(0, 2'b00, 4'b1111, 1, 1);
        chk("t1_hold", q0, 4'b0000);

        // 2: parallel load then hold
        step(0, 2'b11, 4'b1011, 0, 0);
        chk("t2_load", q0, 4'b1011);
        chk("t2_load_nq", nq0, 4'b0100);
        step(0, 2'b00, 4'b0000, 0, 0);
        chk("t2_hold", q0, 4'b1011);

        // 3: shift right from zero
        step(0, 2'b11, 4'b0000, 0, 0);
        step(0, 2'b01, 4'b0000, 1, 0); chk("t3_a", q0, 4'b1000);
        step(0, 2'b01, 4'b0000, 1, 0); chk("t3_b", q0, 4'b1100);
        step(0, 2'b01, 4'b0000, 1, 0); chk("t3_c", q0, 4'b1110);
        step(0, 2'b01, 4'b0000, 1, 0); chk("t3_d", q0, 4'b1111);
        step(0, 2'b01, 4'b0000, 0, 0); chk("t3_e", q0, 4'b0111);

        // 4: shift left from 1011
        step(0, 2'b11, 4'b1011, 0, 0);
        step(0, 2'b10, 4'b0000, 0, 0); chk("t4_a", q0, 4'b0110);
        step(0, 2'b10, 4'b0000, 0, 0); chk("t4_b", q0, 4'b1100);
        step(0, 2'b10, 4'b0000, 0, 1); chk("t4_c", q0, 4'b1001);

        // 5: rotate right via external SR = Q[0]
        step(0, 2'b11, 4'b1011, 0, 0);
        step(0, 2'b01, 4'b0000, model0[0], 0); chk("t5_a", q0, 4'b1101);
        step(0, 2'b01, 4'b0000, model0[0], 0); chk("t5_b", q0, 4'b1110);
        step(0, 2'b01, 4'b0000, model0[0], 0); chk("t5_c", q0, 4'b0111);
        step(0, 2'b01, 4'b0000, model0[0], 0); chk("t5_d", q0, 4'b1011);

        // 6: reset on the second shift edge discards shifted data
        step(0, 2'b11, 4'b1111, 0, 0);
        step(0, 2'b01, 4'b0000, 0, 0); chk("t6_shift", q0, 4'b0111);
        step(1, 2'b01, 4'b0000, 0, 0);
        chk("t6_rst0", q0, 4'b0000);
        chk("t6_rst1", q1, 4'b0101);
        step(0, 2'b01, 4'b0000, 1, 0);
        chk("t6_after0", q0, 4'b1000);
        chk("t6_after1", q1, 4'b1010);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        @(negedge C);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
